// File: rtl/seg_scan_decoder.sv
// Seven-segment scan decoder: recovers the four digits shown on a multiplexed
// display by watching its active-low segment and anode lines.
module seg_scan_decoder #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  segments,
    input  logic [3:0]  anodes,
    output logic [15:0] digits,
    output logic [3:0]  valid,
    output logic        new_digit,
    output logic        frame,
    output logic        err
);
    localparam logic [7:0]  STABLE_MAX  = 8'(STABLE_CYCLES);
    localparam logic [19:0] TIMEOUT_MAX = 20'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, HOLD = 2'd2} state_t;
    typedef enum logic [1:0] {PAT_NUM = 2'd0, PAT_BLANK = 2'd1, PAT_BAD = 2'd2} pat_kind_t;

    logic [6:0]       seg_q;
    logic [3:0]       an_q;
    state_t           state_q, state_d;
    logic [10:0]      ref_q, ref_d;
    logic [7:0]       stab_q, stab_d;
    logic [15:0]      digits_q, digits_d;
    logic [3:0]       valid_q, valid_d;
    logic [3:0]       seen_q, seen_d;
    logic             new_digit_q, new_digit_d;
    logic             frame_q, frame_d;
    logic             err_q, err_d;
    logic [3:0][19:0] tmo_q, tmo_d;

    logic [10:0] sample;
    logic [2:0]  sel_info;
    logic [2:0]  ref_info;
    logic [5:0]  pat_info;
    pat_kind_t   cap_kind;
    logic        capture;

    // {legal, slot}: legal only when exactly one anode line is pulled low.
    function automatic logic [2:0] slot_of(input logic [3:0] an);
        case (an)
            4'b1110: slot_of = 3'b100;
            4'b1101: slot_of = 3'b101;
            4'b1011: slot_of = 3'b110;
            4'b0111: slot_of = 3'b111;
            default: slot_of = 3'b000;
        endcase
    endfunction

    // {kind, value} for an active-low segment pattern.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1000000: decode_seg = {PAT_NUM, 4'd0};
            7'b1111001: decode_seg = {PAT_NUM, 4'd1};
            7'b0100100: decode_seg = {PAT_NUM, 4'd2};
            7'b0110000: decode_seg = {PAT_NUM, 4'd3};
            7'b0011001: decode_seg = {PAT_NUM, 4'd4};
            7'b0010010: decode_seg = {PAT_NUM, 4'd5};
            7'b0000010: decode_seg = {PAT_NUM, 4'd6};
            7'b1111000: decode_seg = {PAT_NUM, 4'd7};
            7'b0000000: decode_seg = {PAT_NUM, 4'd8};
            7'b0010000: decode_seg = {PAT_NUM, 4'd9};
            7'b1111111: decode_seg = {PAT_BLANK, 4'hF};
            default:    decode_seg = {PAT_BAD, 4'h0};
        endcase
    endfunction

    assign sample   = {an_q, seg_q};
    assign sel_info = slot_of(an_q);
    assign ref_info = slot_of(ref_q[10:7]);
    assign pat_info = decode_seg(ref_q[6:0]);
    assign cap_kind = pat_kind_t'(pat_info[5:4]);

    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        stab_d      = stab_q;
        digits_d    = digits_q;
        valid_d     = valid_q;
        seen_d      = seen_q;
        new_digit_d = 1'b0;
        frame_d     = 1'b0;
        err_d       = err_q;
        tmo_d       = tmo_q;
        capture     = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_info[2]) begin
                    ref_d   = sample;
                    stab_d  = 8'd1;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (!sel_info[2]) begin
                    stab_d  = 8'd0;
                    state_d = IDLE;
                end else if (sample != ref_q) begin
                    ref_d  = sample;
                    stab_d = 8'd1;
                end else if (stab_q + 8'd1 == STABLE_MAX) begin
                    stab_d  = STABLE_MAX;
                    capture = 1'b1;
                    state_d = HOLD;
                end else begin
                    stab_d = stab_q + 8'd1;
                end
            end
            HOLD: begin
                if (!sel_info[2]) begin
                    stab_d  = 8'd0;
                    state_d = IDLE;
                end else if (sample != ref_q) begin
                    ref_d   = sample;
                    stab_d  = 8'd1;
                    state_d = TRACK;
                end
            end
            default: begin
                stab_d  = 8'd0;
                state_d = IDLE;
            end
        endcase

        // Slot ageing; a capture below overrides the timeout for its own slot.
        for (int k = 0; k < 4; k++) begin
            if (tmo_q[k] != TIMEOUT_MAX) begin
                tmo_d[k] = tmo_q[k] + 20'd1;
            end
            if (tmo_d[k] == TIMEOUT_MAX) begin
                valid_d[k] = 1'b0;
            end
        end

        // A full mask is reported one cycle after it fills, then restarts.
        if (seen_q == 4'b1111) begin
            frame_d = 1'b1;
            seen_d  = 4'b0000;
        end

        if (capture) begin
            tmo_d[ref_info[1:0]] = 20'd0;
            case (cap_kind)
                PAT_NUM: begin
                    digits_d[{ref_info[1:0], 2'b00} +: 4] = pat_info[3:0];
                    valid_d[ref_info[1:0]] = 1'b1;
                    seen_d[ref_info[1:0]]  = 1'b1;
                    new_digit_d = 1'b1;
                end
                PAT_BLANK: begin
                    digits_d[{ref_info[1:0], 2'b00} +: 4] = 4'hF;
                    valid_d[ref_info[1:0]] = 1'b0;
                    seen_d[ref_info[1:0]]  = 1'b1;
                end
                default: begin
                    valid_d[ref_info[1:0]] = 1'b0;
                    err_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q       <= '1;
            an_q        <= '1;
            state_q     <= IDLE;
            ref_q       <= '1;
            stab_q      <= '0;
            digits_q    <= 16'hFFFF;
            valid_q     <= '0;
            seen_q      <= '0;
            new_digit_q <= 1'b0;
            frame_q     <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            seg_q       <= segments;
            an_q        <= anodes;
            state_q     <= state_d;
            ref_q       <= ref_d;
            stab_q      <= stab_d;
            digits_q    <= digits_d;
            valid_q     <= valid_d;
            seen_q      <= seen_d;
            new_digit_q <= new_digit_d;
            frame_q     <= frame_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign digits    = digits_q;
    assign valid     = valid_q;
    assign new_digit = new_digit_q;
    assign frame     = frame_q;
    assign err       = err_q;

endmodule
